// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> MEM -> COMMIT over one shared memory port.
// Latency (zero-wait memory): ALU/lui/branch 4 cycles, lw/sw 5, jumps 3, syscall 3 + handler cycles.
// Backpressure: mem_ready low stalls FETCH/MEM (FAULT after MAX_WAIT cycles); syscall_done low stalls SYSCALL.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-high reset (highest priority)
//   run               leave IDLE / continue after COMMIT (sampled only in those states)
//   opcode[4:0]       IR opcode, sampled in DECODE into op_q
//   mem_ready         acknowledge for mem_req (ignored outside FETCH/MEM)
//   syscall_done      handler completion (ignored outside SYSCALL)
//   mem_req, mem_we, mem_sel_data, ir_write, alu_en, reg_wb, pc_write, syscall_req
//                     datapath controls, combinational from state, op_q and mem_ready
//   halted, fault     sticky terminal indications (held until reset)
//   retired[CNT_W-1:0] retired-instruction counter, wraps
//   state_o[3:0]      current state encoding for debug
module multicycle_sequencer #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic             mem_ready,
  input  logic             syscall_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             ir_write,
  output logic             alu_en,
  output logic             reg_wb,
  output logic             pc_write,
  output logic             syscall_req,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_MEM     = 4'd4,
    S_SYSCALL = 4'd5,
    S_COMMIT  = 4'd6,
    S_HALT    = 4'd7,
    S_FAULT   = 4'd8
  } state_t;

  localparam logic [4:0] OP_SW      = 5'b00001;
  localparam logic [4:0] OP_JAL     = 5'b00010;
  localparam logic [4:0] OP_BEQ     = 5'b00101;
  localparam logic [4:0] OP_J       = 5'b00110;
  localparam logic [4:0] OP_LW      = 5'b01001;
  localparam logic [4:0] OP_JR      = 5'b01010;
  localparam logic [4:0] OP_BNE     = 5'b01101;
  localparam logic [4:0] OP_SYSCALL = 5'b10110;
  localparam logic [4:0] OP_EXIT    = 5'b11111;

  // Last wait count at which an unacknowledged request is still tolerated.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_op_q;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_retired;

  logic w_wait_inc;   // request outstanding and not yet timed out
  logic w_retire;     // COMMIT cycle: count the instruction
  logic w_latch_op;   // DECODE cycle: capture opcode
  logic w_no_wb;      // instruction has no register-file result

  assign w_no_wb = (r_op_q == OP_SW) || (r_op_q == OP_BEQ) || (r_op_q == OP_BNE) ||
                   (r_op_q == OP_J)  || (r_op_q == OP_JR)  || (r_op_q == OP_SYSCALL);

  assign retired = r_retired;
  assign state_o = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op_q     <= 5'd0;
      r_wait_cnt <= 8'd0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch_op) begin
        r_op_q <= opcode;
      end
      // Anything other than an outstanding, still-legal wait zeroes the
      // counter, so every entry into FETCH or MEM starts from 0.
      r_wait_cnt <= w_wait_inc ? (r_wait_cnt + 8'd1) : 8'd0;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_wait_inc   = 1'b0;
    w_retire     = 1'b0;
    w_latch_op   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    alu_en       = 1'b0;
    reg_wb       = 1'b0;
    pc_write     = 1'b0;
    syscall_req  = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = S_DECODE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next = S_FAULT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        // Branch on the live opcode; op_q holds it from the next cycle on.
        w_latch_op = 1'b1;
        case (opcode)
          OP_EXIT:               w_next = S_HALT;
          OP_SYSCALL:            w_next = S_SYSCALL;
          OP_JAL, OP_J, OP_JR:   w_next = S_COMMIT;
          default:               w_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        alu_en = 1'b1;
        if ((r_op_q == OP_LW) || (r_op_q == OP_SW)) begin
          w_next = S_MEM;
        end else begin
          w_next = S_COMMIT;
        end
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (r_op_q == OP_SW);
        if (mem_ready) begin
          w_next = S_COMMIT;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next = S_FAULT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_SYSCALL: begin
        syscall_req = 1'b1;
        if (syscall_done) begin
          w_next = S_COMMIT;
        end
      end

      S_COMMIT: begin
        pc_write = 1'b1;
        reg_wb   = !w_no_wb;
        w_retire = 1'b1;
        w_next   = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam logic [4:0] LUI  = 5'b10101;
  localparam logic [4:0] LW   = 5'b01001;
  localparam logic [4:0] SW   = 5'b00001;
  localparam logic [4:0] J    = 5'b00110;
  localparam logic [4:0] JAL  = 5'b00010;
  localparam logic [4:0] JR   = 5'b01010;
  localparam logic [4:0] BEQ  = 5'b00101;
  localparam logic [4:0] SYS  = 5'b10110;
  localparam logic [4:0] EXIT = 5'b11111;

  // Output vector bits: mem_req, mem_we, mem_sel_data, ir_write, alu_en,
  // reg_wb, pc_write, syscall_req, halted, fault
  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_FRDY  = 10'b1001000000;
  localparam logic [9:0] O_FNR   = 10'b1000000000;
  localparam logic [9:0] O_EXEC  = 10'b0000100000;
  localparam logic [9:0] O_MLD   = 10'b1010000000;
  localparam logic [9:0] O_MST   = 10'b1110000000;
  localparam logic [9:0] O_CWB   = 10'b0000011000;
  localparam logic [9:0] O_CNWB  = 10'b0000001000;
  localparam logic [9:0] O_SYS   = 10'b0000000100;
  localparam logic [9:0] O_HALT  = 10'b0000000010;
  localparam logic [9:0] O_FAULT = 10'b0000000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [4:0] opcode;
  logic       mem_ready;
  logic       syscall_done;
  logic       mem_req, mem_we, mem_sel_data, ir_write, alu_en, reg_wb, pc_write;
  logic       syscall_req, halted, fault;
  logic [3:0] retired;
  logic [3:0] state_o;
  logic [9:0] outs;

  assign outs = {mem_req, mem_we, mem_sel_data, ir_write, alu_en,
                 reg_wb, pc_write, syscall_req, halted, fault};

  multicycle_sequencer #(.MAX_WAIT(16), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .syscall_done (syscall_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel_data (mem_sel_data),
    .ir_write     (ir_write),
    .alu_en       (alu_en),
    .reg_wb       (reg_wb),
    .pc_write     (pc_write),
    .syscall_req  (syscall_req),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [4:0] op;
    logic       rdy;
    logic       sdone;
    logic [3:0] st;
    logic [9:0] outs;
    logic [3:0] ret;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add_vec(input logic r, input logic [4:0] op, input logic rdy, input logic sd,
                         input logic [3:0] st, input logic [9:0] o, input logic [3:0] ret);
    vec_t v;
    v.run = r; v.op = op; v.rdy = rdy; v.sdone = sd;
    v.st = st; v.outs = o; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs may be changed right after this returns.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_clean(input string tag);
    chk({tag, " state"}, 32'(state_o), 32'd0);
    chk({tag, " outs"}, 32'(outs), 32'd0);
    chk({tag, " retired"}, 32'(retired), 32'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; run = 1'b0; opcode = 5'd0; mem_ready = 1'b0; syscall_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_idle_clean("reset");

    // lui
    add_vec(1, LUI, 1, 0, 0, O_NONE, 0);
    add_vec(1, LUI, 1, 0, 1, O_FRDY, 0);
    add_vec(1, LUI, 1, 0, 2, O_NONE, 0);
    add_vec(1, LUI, 1, 0, 3, O_EXEC, 0);
    add_vec(1, LUI, 1, 0, 6, O_CWB, 0);
    // lw, three wait cycles in MEM
    add_vec(1, LW, 1, 0, 1, O_FRDY, 1);
    add_vec(1, LW, 1, 0, 2, O_NONE, 1);
    add_vec(1, LW, 1, 0, 3, O_EXEC, 1);
    add_vec(1, LW, 0, 0, 4, O_MLD, 1);
    add_vec(1, LW, 0, 0, 4, O_MLD, 1);
    add_vec(1, LW, 0, 0, 4, O_MLD, 1);
    add_vec(1, LW, 1, 0, 4, O_MLD, 1);
    add_vec(1, LW, 1, 0, 6, O_CWB, 1);
    // sw
    add_vec(1, SW, 1, 0, 1, O_FRDY, 2);
    add_vec(1, SW, 1, 0, 2, O_NONE, 2);
    add_vec(1, SW, 1, 0, 3, O_EXEC, 2);
    add_vec(1, SW, 1, 0, 4, O_MST, 2);
    add_vec(1, SW, 1, 0, 6, O_CNWB, 2);
    // j
    add_vec(1, J, 1, 0, 1, O_FRDY, 3);
    add_vec(1, J, 1, 0, 2, O_NONE, 3);
    add_vec(1, J, 1, 0, 6, O_CNWB, 3);
    // jal
    add_vec(1, JAL, 1, 0, 1, O_FRDY, 4);
    add_vec(1, JAL, 1, 0, 2, O_NONE, 4);
    add_vec(1, JAL, 1, 0, 6, O_CWB, 4);
    // beq with two fetch wait cycles, run dropped at COMMIT
    add_vec(1, BEQ, 0, 0, 1, O_FNR, 5);
    add_vec(1, BEQ, 0, 0, 1, O_FNR, 5);
    add_vec(1, BEQ, 1, 0, 1, O_FRDY, 5);
    add_vec(1, BEQ, 1, 0, 2, O_NONE, 5);
    add_vec(1, BEQ, 1, 0, 3, O_EXEC, 5);
    add_vec(0, BEQ, 1, 0, 6, O_CNWB, 5);
    // IDLE ignores mem_ready/syscall_done, resumes on run
    add_vec(0, BEQ, 1, 1, 0, O_NONE, 6);
    add_vec(0, BEQ, 1, 1, 0, O_NONE, 6);
    add_vec(1, BEQ, 1, 0, 0, O_NONE, 6);
    // syscall, handler done after 5 cycles; run low mid-instruction
    add_vec(1, SYS, 1, 0, 1, O_FRDY, 6);
    add_vec(1, SYS, 1, 0, 2, O_NONE, 6);
    for (int k = 0; k < 5; k++) add_vec(0, SYS, 1, 0, 5, O_SYS, 6);
    add_vec(0, SYS, 1, 1, 5, O_SYS, 6);
    add_vec(1, SYS, 1, 0, 6, O_CNWB, 6);
    // jr
    add_vec(1, JR, 1, 0, 1, O_FRDY, 7);
    add_vec(1, JR, 1, 0, 2, O_NONE, 7);
    add_vec(1, JR, 1, 0, 6, O_CNWB, 7);
    // exit
    add_vec(1, EXIT, 1, 0, 1, O_FRDY, 8);
    add_vec(1, EXIT, 1, 0, 2, O_NONE, 8);
    add_vec(1, EXIT, 1, 0, 7, O_HALT, 8);
    add_vec(1, EXIT, 1, 0, 7, O_HALT, 8);
    add_vec(1, EXIT, 1, 1, 7, O_HALT, 8);

    foreach (tbl[i]) begin
      run = tbl[i].run; opcode = tbl[i].op;
      mem_ready = tbl[i].rdy; syscall_done = tbl[i].sdone;
      #1;
      chk($sformatf("row%0d state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("row%0d outs", i), 32'(outs), 32'(tbl[i].outs));
      chk($sformatf("row%0d retired", i), 32'(retired), 32'(tbl[i].ret));
      tick();
    end

    // Reset out of HALT clears the counter
    run = 1'b0; mem_ready = 1'b0; syscall_done = 1'b0;
    do_reset();
    chk_idle_clean("halt_reset");

    // Fetch acked after 14 wait cycles still decodes
    run = 1'b1; opcode = LUI; mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 14; k++) tick();
    chk("late_ack state", 32'(state_o), 32'd1);
    chk("late_ack outs_wait", 32'(outs), 32'(O_FNR));
    mem_ready = 1'b1;
    #1;
    chk("late_ack outs_ack", 32'(outs), 32'(O_FRDY));
    tick();
    chk("late_ack decode", 32'(state_o), 32'd2);

    // Fetch timeout
    do_reset();
    run = 1'b1; mem_ready = 1'b0;
    tick();
    n = 0;
    while (state_o == 4'd1 && n < 40) begin
      n++;
      tick();
    end
    chk("fetch_to cycles", 32'(n), 32'd16);
    chk("fetch_to state", 32'(state_o), 32'd8);
    chk("fetch_to outs", 32'(outs), 32'(O_FAULT));
    mem_ready = 1'b1;
    tick();
    tick();
    chk("fault sticky state", 32'(state_o), 32'd8);
    chk("fault sticky outs", 32'(outs), 32'(O_FAULT));
    do_reset();
    chk_idle_clean("fault_reset");

    // MEM timeout on sw
    run = 1'b1; opcode = SW; mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("mem_to in_mem", 32'(state_o), 32'd4);
    chk("mem_to outs", 32'(outs), 32'(O_MST));
    n = 0;
    while (state_o == 4'd4 && n < 40) begin
      n++;
      tick();
    end
    chk("mem_to cycles", 32'(n), 32'd16);
    chk("mem_to state", 32'(state_o), 32'd8);
    do_reset();

    // retired wraps (CNT_W=4) over 17 jumps
    run = 1'b1; opcode = J; mem_ready = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      tick(); tick(); tick();
      chk($sformatf("wrap retired k=%0d", k), 32'(retired), 32'(k % 16));
    end
    chk("wrap back_to_fetch", 32'(state_o), 32'd1);

    // Reset in the middle of a MEM wait
    opcode = LW;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    chk("mid_wait in_mem", 32'(state_o), 32'd4);
    chk("mid_wait outs", 32'(outs), 32'(O_MLD));
    do_reset();
    chk_idle_clean("mid_wait_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
